// File: rtl/calc_pkg.sv
// Shared key codes, key classes and enums for the keypad calculator controller.
package calc_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_EQUALS    = 4'hB;
    localparam logic [3:0] KEY_UNUSED    = 4'hC;
    localparam logic [3:0] KEY_MUL       = 4'hD;
    localparam logic [3:0] KEY_SUB       = 4'hE;
    localparam logic [3:0] KEY_ADD       = 4'hF;

    localparam logic [1:0] CLS_CLEAR = 2'b01;
    localparam logic [1:0] CLS_OP    = 2'b10;
    localparam logic [1:0] CLS_EQ    = 2'b11;

    typedef enum logic [1:0] {ADD, SUB, MUL} op_e;

    typedef enum logic [1:0] {OPA, OPB, COMPUTE, SHOW} state_e;

    typedef enum logic [2:0] {K_NONE, K_DIGIT, K_OPER, K_EQ, K_CLR} key_e;

    // Digits win regardless of class; an operator class only counts for D/E/F.
    function automatic key_e decode_key(input logic [3:0] code, input logic [1:0] cls);
        if (code <= KEY_DIGIT_MAX) return K_DIGIT;
        if (cls == CLS_OP) begin
            if (code == KEY_MUL || code == KEY_SUB || code == KEY_ADD) return K_OPER;
            return K_NONE;
        end
        if (cls == CLS_EQ) return K_EQ;
        if (cls == CLS_CLEAR && code == KEY_CLEAR) return K_CLR;
        return K_NONE;
    endfunction

    function automatic op_e op_from_key(input logic [3:0] code);
        case (code)
            KEY_MUL: return MUL;
            KEY_SUB: return SUB;
            default: return ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_controller_mult.sv
// Shift-add multiplier: one multiplier bit per cycle, W cycles after start.
module seq_multiplier #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q;
    logic           run_q;

    // Product is offered combinationally in the last working cycle so the
    // controller can load it on the same edge that retires the final bit.
    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        product_o = acc_d;
        done_o    = run_q && (cnt_q == CW'(1));
    end

    // Operand shift registers, accumulator and cycle down-counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= CW'(W);
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_controller.sv
// Keypad calculator controller: operand entry, +/-/x on equals, display select.
//   state   | meaning
//   OPA     | entering first operand (or cleared)
//   OPB     | operator latched, entering second operand
//   COMPUTE | arithmetic in progress, keys dropped
//   SHOW    | result held in opA, awaiting next key
module calc_controller
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         keyValid,
    input  logic [3:0]   keyCode,
    input  logic [1:0]   stateEncoder,
    output logic [W-1:0] displayValue,
    output logic         negative,
    output logic         overflow,
    output logic         busy,
    output logic         resultValid
);
    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic           b_entered_q, b_entered_d;
    logic           negative_q, negative_d;
    logic           overflow_q, overflow_d;
    logic           result_valid_q, result_valid_d;

    key_e           key;
    logic [W+3:0]   acc_a, acc_b;
    logic [W:0]     sum;
    logic           mul_start, mul_done;
    logic [2*W-1:0] product;

    seq_multiplier #(.W(W)) u_mult (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .start_i  (mul_start),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .done_o   (mul_done),
        .product_o(product)
    );

    // Key classification and the candidate operand/sum values.
    always_comb begin
        key = K_NONE;
        if (keyValid && state_q != COMPUTE) key = decode_key(keyCode, stateEncoder);
        acc_a = {4'b0, opa_q} * (W+4)'(10) + (W+4)'(keyCode);
        acc_b = {4'b0, opb_q} * (W+4)'(10) + (W+4)'(keyCode);
        sum   = {1'b0, opa_q} + {1'b0, opb_q};
    end

    // Next-state and register updates for the sequencing FSM.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        b_entered_d    = b_entered_q;
        negative_d     = negative_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;
        mul_start      = 1'b0;

        if (key == K_CLR) begin
            state_d     = OPA;
            op_d        = ADD;
            opa_d       = '0;
            opb_d       = '0;
            b_entered_d = 1'b0;
            negative_d  = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            unique case (state_q)
                OPA: begin
                    if (key == K_DIGIT && acc_a[W+3:W] == '0) opa_d = acc_a[W-1:0];
                    if (key == K_OPER) begin
                        op_d        = op_from_key(keyCode);
                        opb_d       = '0;
                        b_entered_d = 1'b0;
                        state_d     = OPB;
                    end
                end
                OPB: begin
                    if (key == K_DIGIT) begin
                        if (acc_b[W+3:W] == '0) opb_d = acc_b[W-1:0];
                        b_entered_d = 1'b1;
                    end
                    if (key == K_OPER) op_d = op_from_key(keyCode);
                    if (key == K_EQ) begin
                        state_d   = COMPUTE;
                        mul_start = (op_q == MUL);
                    end
                end
                COMPUTE: begin
                    unique case (op_q)
                        ADD: begin
                            opa_d          = sum[W-1:0];
                            overflow_d     = sum[W];
                            negative_d     = 1'b0;
                            state_d        = SHOW;
                            result_valid_d = 1'b1;
                        end
                        SUB: begin
                            if (opa_q >= opb_q) begin
                                opa_d      = opa_q - opb_q;
                                negative_d = 1'b0;
                            end else begin
                                opa_d      = opb_q - opa_q;
                                negative_d = 1'b1;
                            end
                            overflow_d     = 1'b0;
                            state_d        = SHOW;
                            result_valid_d = 1'b1;
                        end
                        default: begin
                            if (mul_done) begin
                                opa_d          = product[W-1:0];
                                overflow_d     = |product[2*W-1:W];
                                negative_d     = 1'b0;
                                state_d        = SHOW;
                                result_valid_d = 1'b1;
                            end
                        end
                    endcase
                end
                SHOW: begin
                    if (key == K_DIGIT) begin
                        opa_d      = W'(keyCode);
                        negative_d = 1'b0;
                        overflow_d = 1'b0;
                        state_d    = OPA;
                    end
                    if (key == K_OPER) begin
                        negative_d  = 1'b0;
                        overflow_d  = 1'b0;
                        op_d        = op_from_key(keyCode);
                        opb_d       = '0;
                        b_entered_d = 1'b0;
                        state_d     = OPB;
                    end
                end
                default: state_d = OPA;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= OPA;
            op_q           <= ADD;
            opa_q          <= '0;
            opb_q          <= '0;
            b_entered_q    <= 1'b0;
            negative_q     <= 1'b0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            b_entered_q    <= b_entered_d;
            negative_q     <= negative_d;
            overflow_q     <= overflow_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign displayValue = (state_q == OPB && b_entered_q) ? opb_q : opa_q;
    assign negative     = negative_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q == COMPUTE);
    assign resultValid  = result_valid_q;

endmodule

// File: doc/calc_controller.md
# calc_controller

Sequential datapath controller for the keypad calculator. It consumes the raw 4-bit key code plus the 2-bit key-class code produced by the operator state encoder (01 clear, 10 arithmetic operator, 11 equals) and decodes them. It accumulates two decimal operands, performs +, − or × on equals, and drives the value to be displayed. It sits between the keypad/encoder stage and the display driver.

## Interface
- W, 8: operand/result width in bits (unsigned magnitude).
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- keyValid  in  1  one-cycle strobe: keyCode/stateEncoder valid this cycle.
- keyCode  in  4  raw key: 0–9 digit, A clear, B equals, D ×, E −, F +; C unused.
- stateEncoder  in  2  key class from encoder: 01 clear/default, 10 operator, 11 equals.
- displayValue  out  W  value for display driver.
- negative  out  1  last result was negative (displayValue is magnitude).
- overflow  out  1  last result exceeded W bits.
- busy  out  1  computation in progress; keys ignored.
- resultValid  out  1  one-cycle pulse when a new result is loaded.

## Operation
- Key decode (only when keyValid=1 and busy=0): keyCode ≤ 9 → DIGIT; else stateEncoder 10 → OP (keyCode selects D/E/F); 11 → EQ; 01 with keyCode A → CLEAR; anything else (keyCode C) → ignored.
- Registers: opA, opB (W bits), op (ADD/SUB/MUL), bEntered flag, negative, overflow.
- States: OPA, OPB, COMPUTE, SHOW. Reset and CLEAR (in any non-COMPUTE state) → OPA, all registers and outputs 0.
- OPA: DIGIT → opA = opA·10 + d, unless result > 2^W−1, then digit discarded, opA unchanged. OP → latch op, opB=0, bEntered=0, → OPB. EQ ignored.
- OPB: DIGIT → accumulate into opB (same saturation rule), bEntered=1. OP → overwrite op, opB unchanged. EQ → COMPUTE.
- COMPUTE: ADD: sum of W+1 bits; overflow = carry; result = low W bits. SUB: if opA ≥ opB result = opA−opB, negative=0; else result = opB−opA, negative=1; overflow=0. MUL: shift-add, 2W-bit product; overflow = any upper W bits set; result = low W bits. On completion: opA=result, → SHOW, resultValid pulse.
- SHOW: DIGIT → opA=d, negative=0, overflow=0, → OPA. OP → chain: opA (magnitude) kept, negative=0, overflow=0, latch op, opB=0, bEntered=0, → OPB. EQ ignored.
- displayValue: OPA/SHOW/COMPUTE → opA; OPB → opB if bEntered else opA.

## Timing
- Reset values: displayValue 0, negative 0, overflow 0, busy 0, resultValid 0, state OPA.
- Digit/operator/clear effects visible on outputs the cycle after the keyValid cycle.
- EQ accepted in cycle n: busy=1 from n+1 through the last COMPUTE cycle.
- ADD/SUB: one COMPUTE cycle; resultValid and new displayValue in cycle n+2.
- MUL: W COMPUTE cycles (one multiplier bit per cycle); resultValid in cycle n+W+1.
- keyValid during busy: dropped, no buffering, including CLEAR. Reset during COMPUTE aborts immediately; no resultValid.
- Reset and keyValid in the same cycle: Reset wins.

## Structure
- Package calc_pkg: key code constants (digits, A/B/C/D/E/F), class encodings 01/10/11, op enum {ADD, SUB, MUL}, state enum {OPA, OPB, COMPUTE, SHOW}.
- Sub-module seq_multiplier (W param): start/done handshake, W-cycle shift-add, 2W-bit product. Add/sub stay inline.

## Test plan
- Reset, keys 1,2,+,3,4,= → displayValue 46, negative 0, overflow 0, resultValid exactly in cycle n+2 after '='.
- Keys 5,−,9,= → displayValue 4, negative 1; then +,1,= → 5, negative 0.
- Keys 2,0,×,1,3,= → displayValue 4 (260 mod 256), overflow 1, resultValid 9 cycles after '=', busy high 8 cycles.
- Keys 2,5,6 → displayValue 25 (third digit discarded); keys 2,0,0,+,1,0,0,= → 44, overflow 1.
- During a multiply, issue keyValid CLEAR and digits → ignored, result as normal; then Reset in mid-multiply → all outputs 0, no resultValid.
- Key C, '=' in OPA, and '+' followed by '−' before any digit → no effect, no effect, op becomes SUB (7,+,−,2,= → 5).
